uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter. It serializes one parallel byte into a frame: start bit, LSB-first data, optional parity, stop.
- Drives the serial line that the UART receive path samples.
- Each bit period is `prescale` clocks, the same prescale convention as the RX side, so one clock and one prescale value serve both directions.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of prescale input and of the internal edge counter.

Ports:
- CLK_TX  input  1  transmit clock.
- RST_TX  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on accept.
- DATA_VALID  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = parity bit inserted; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- prescale  input  PRESCALE_WIDTH  clocks per bit; sampled on accept.
- TX_OUT  output  1  serial line; idle high.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Interface: one clock (CLK_TX). Reset RST_TX is asynchronous and active-low.
- Reset values: TX_OUT=1, busy=0, state=IDLE, edge counter=0, bit counter=0, shadow registers=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If DATA_VALID=1 at a rising edge, accept at that edge:
    - latch P_DATA, PAR_EN, PAR_TYP and the effective prescale into shadow registers;
    - compute parity into a shadow register;
    - go to START with TX_OUT<=0, busy<=1, edge_cnt<=0.
  - The start bit therefore appears one clock after DATA_VALID is sampled.
- Effective prescale: prescale values 0..3 are clamped to 4; all others are used as-is.
- Bit timing:
  - edge_cnt counts 0..prescale_s-1 in every non-IDLE state.
  - A bit ends when edge_cnt==prescale_s-1. At that edge, edge_cnt<=0 and the next bit value is loaded into TX_OUT.
  - Each bit holds exactly prescale_s clocks.
- START to DATA after one bit.
- DATA:
  - Sends shadow data bit bit_cnt, LSB first; bit_cnt counts 0..DATA_WIDTH-1.
  - After the last data bit, go to PARITY if PAR_EN_s=1, else to STOP.
- PARITY:
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = XNOR of the data bits.
  - One bit period, then STOP.
- STOP:
  - TX_OUT=1 for one bit period.
  - At its final edge, go to IDLE with busy<=0.
- DATA_VALID while busy=1 is ignored and not queued.
- Minimum inter-frame gap is 1 idle clock, because accept happens only in IDLE.
- Changes to P_DATA, PAR_EN, PAR_TYP or prescale mid-frame have no effect on the frame in flight.
- Frame length: (1 + DATA_WIDTH + PAR_EN_s + 1) × prescale_s clocks of busy=1.
- Reset asserted mid-frame: TX_OUT=1 and busy=0 immediately (asynchronously). The frame is abandoned, not resumed.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: the STOP state lasts two bit periods (2 × prescale_s clocks high, tracked by reusing bit_cnt), and frame length gains one prescale_s.
- Undefined: exactly one stop bit.
- No port change either way.

Decomposition:
- Package uart_tx_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, 3-bit);
  - localparam MIN_PRESCALE=4;
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1.
- One natural sub-module: uart_tx_parity, combinational, DATA_WIDTH input plus PAR_TYP giving the parity bit. The main FSM registers its output at accept.

Test Plan:
- prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one-cycle DATA_VALID:
  - TX_OUT = 0,1,0,1,0,0,1,0,1,0(parity),1, each held 8 clocks;
  - busy high exactly 88 clocks, starting one clock after the accept edge.
- prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=0x01: parity bit = 0; busy = 176 clocks.
- prescale=8, PAR_EN=0, P_DATA=0xFF: start 0, then 9 bits high; busy = 80 clocks, no parity slot.
- During a frame, pulse DATA_VALID with P_DATA=0x3C and change prescale to 4:
  - the current frame is unchanged and no second frame is sent;
  - DATA_VALID held through IDLE starts the next frame after a 1-clock gap.
- prescale=2: bits last 4 clocks (clamp).
- Reset deassert-assert at clock 30 of a frame: TX_OUT=1 and busy=0 without a clock edge; the next DATA_VALID after release sends a full fresh frame.
- With UART_TX_TWO_STOP_EN defined, the 0xA5 / prescale=8 / even-parity case gives a 96-clock busy with 16 clocks of stop high.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared types and constants for the UART transmit frame path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam int   MIN_PRESCALE = 4;
    localparam logic PAR_EVEN     = 1'b0;
    localparam logic PAR_ODD      = 1'b1;

endpackage : uart_tx_pkg

`default_nettype wire

// File: rtl/uart_tx_parity.sv
// ============================================================================
// Module   : uart_tx_parity
// Brief    : Combinational even/odd parity generator for one payload word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_parity
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_o
);

    always_comb begin
        par_o = ^data_i;
        case (par_typ_i)
            PAR_EVEN: par_o = ^data_i;
            PAR_ODD:  par_o = ~(^data_i);
            default:  par_o = ^data_i;
        endcase
    end

endmodule : uart_tx_parity

`default_nettype wire

// File: rtl/uart_tx_frame.sv
// ============================================================================
// Module   : uart_tx_frame
// Brief    : UART transmitter: start, LSB-first data, optional parity, stop.
//            Define UART_TX_TWO_STOP_EN for two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK_TX,
    input  logic                      RST_TX,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e                 state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     data_s_q, data_s_d;
    logic                      par_en_s_q, par_en_s_d;
    logic                      par_typ_s_q, par_typ_s_d;
    logic                      par_bit_q, par_bit_d;
    logic [PRESCALE_WIDTH-1:0] prescale_s_q, prescale_s_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic                      w_par;
    logic [PRESCALE_WIDTH-1:0] w_prescale_eff;
    logic                      w_bit_end;
    logic [BCW-1:0]            w_bit_nxt;

    uart_tx_parity #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (P_DATA),
        .par_typ_i (PAR_TYP),
        .par_o     (w_par)
    );

    // Very short bit periods are stretched so the receiver can still sample mid-bit.
    assign w_prescale_eff = (prescale < PRESCALE_WIDTH'(MIN_PRESCALE)) ?
                            PRESCALE_WIDTH'(MIN_PRESCALE) : prescale;
    assign w_bit_end      = (edge_cnt_q == (prescale_s_q - PRESCALE_WIDTH'(1)));
    assign w_bit_nxt      = bit_cnt_q + BCW'(1);

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        data_s_d     = data_s_q;
        par_en_s_d   = par_en_s_q;
        par_typ_s_d  = par_typ_s_q;
        par_bit_d    = par_bit_q;
        prescale_s_d = prescale_s_q;
        tx_d         = tx_q;
        busy_d       = busy_q;

        if (state_q != IDLE) begin
            edge_cnt_d = w_bit_end ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (DATA_VALID) begin
                    data_s_d     = P_DATA;
                    par_en_s_d   = PAR_EN;
                    par_typ_s_d  = PAR_TYP;
                    par_bit_d    = w_par;
                    prescale_s_d = w_prescale_eff;
                    state_d      = START;
                    tx_d         = 1'b0;
                    busy_d       = 1'b1;
                    edge_cnt_d   = '0;
                    bit_cnt_d    = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = data_s_q[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        if (par_en_s_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = w_bit_nxt;
                        tx_d      = data_s_q[w_bit_nxt];
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (w_bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (bit_cnt_q == '0) begin
                        bit_cnt_d = BCW'(1);
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
`else
                    state_d = IDLE;
                    busy_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK_TX or negedge RST_TX) begin
        if (!RST_TX) begin
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            data_s_q     <= '0;
            par_en_s_q   <= 1'b0;
            par_typ_s_q  <= 1'b0;
            par_bit_q    <= 1'b0;
            prescale_s_q <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            data_s_q     <= data_s_d;
            par_en_s_q   <= par_en_s_d;
            par_typ_s_q  <= par_typ_s_d;
            par_bit_q    <= par_bit_d;
            prescale_s_q <= prescale_s_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule : uart_tx_frame

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Randomized self-checking bench for uart_tx_frame against a
//            bit-list reference model of the serial frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame;

    localparam int DW    = 8;
    localparam int PW    = 6;
    localparam int LIMIT = 2000;
`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    logic          CLK_TX = 1'b0;
    logic          RST_TX;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] prescale;
    logic          TX_OUT;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_wave[$];

    uart_tx_frame #(
        .DATA_WIDTH     (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .CLK_TX     (CLK_TX),
        .RST_TX     (RST_TX),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .prescale   (prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK_TX = ~CLK_TX;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_ps(input int ps);
        return (ps < 4) ? 4 : ps;
    endfunction

    // Frame as a list of line levels, one entry per clock of busy.
    task automatic build_wave(input logic [DW-1:0] d, input bit pe, input bit pt, input int ps);
        bit bits[$];
        exp_wave.delete();
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(bit'($countones(d) % 2) ^ pt);
        for (int i = 0; i < N_STOP; i++) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < eff_ps(ps); k++) exp_wave.push_back(bits[i]);
    endtask

    task automatic drive_accept(input logic [DW-1:0] d, input bit pe, input bit pt, input int ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = PW'(ps);
        DATA_VALID = 1'b1;
        @(posedge CLK_TX);
        @(negedge CLK_TX);
    endtask

    task automatic capture(input logic [DW-1:0] d, input bit pe, input bit pt, input int ps,
                           input int inj_at, output int len);
        int n   = 0;
        bit bad = 0;
        build_wave(d, pe, pt, ps);
        while (busy === 1'b1 && n < LIMIT) begin
            if (!bad && n < exp_wave.size()) begin
                check_eq($sformatf("tx_d%02h_ps%0d_clk%0d", d, ps, n), TX_OUT, exp_wave[n]);
                if (TX_OUT !== exp_wave[n]) bad = 1;
            end
            if (inj_at >= 0 && n == inj_at) begin
                DATA_VALID = 1'b1;
                P_DATA     = 8'h3C;
                prescale   = PW'(4);
            end
            if (inj_at >= 0 && n == inj_at + 1) DATA_VALID = 1'b0;
            @(negedge CLK_TX);
            n++;
        end
        if (n >= LIMIT) check_eq("busy_timeout", n, 0);
        check_eq($sformatf("busy_len_d%02h", d), n, exp_wave.size());
        check_eq("idle_tx", TX_OUT, 1);
        len = n;
    endtask

    initial begin
        int len, len2, cnt;
        logic [DW-1:0] rd;
        bit rpe, rpt;
        int rps;

        RST_TX = 1'b0; DATA_VALID = 1'b0; P_DATA = '0;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = PW'(8);
        repeat (3) @(negedge CLK_TX);
        check_eq("rst_tx", TX_OUT, 1);
        check_eq("rst_busy", busy, 0);
        RST_TX = 1'b1;
        repeat (2) @(negedge CLK_TX);

        drive_accept(8'hA5, 1, 0, 8); DATA_VALID = 1'b0;
        capture(8'hA5, 1, 0, 8, -1, len);
        check_eq("a5_len", len, 88 + (N_STOP - 1) * 8);

        drive_accept(8'h01, 1, 1, 16); DATA_VALID = 1'b0;
        capture(8'h01, 1, 1, 16, -1, len);
        check_eq("odd01_len", len, 176 + (N_STOP - 1) * 16);

        drive_accept(8'hFF, 0, 0, 8); DATA_VALID = 1'b0;
        capture(8'hFF, 0, 0, 8, -1, len);
        check_eq("ff_nopar_len", len, 80 + (N_STOP - 1) * 8);

        // Mid-frame request and prescale change must be ignored.
        drive_accept(8'h96, 1, 0, 6); DATA_VALID = 1'b0;
        capture(8'h96, 1, 0, 6, 20, len);
        cnt = 0;
        repeat (30) begin
            if (busy !== 1'b0) cnt++;
            @(negedge CLK_TX);
        end
        check_eq("no_queued_frame", cnt, 0);

        // Request held through the end of a frame: exactly one idle clock.
        drive_accept(8'h5A, 0, 1, 5);
        capture(8'h5A, 0, 1, 5, -1, len);
        @(negedge CLK_TX);
        DATA_VALID = 1'b0;
        capture(8'h5A, 0, 1, 5, -1, len2);
        check_eq("back_to_back_len", len2, len);

        drive_accept(8'h33, 1, 1, 2); DATA_VALID = 1'b0;
        capture(8'h33, 1, 1, 2, -1, len);
        check_eq("clamp_len", len, (11 + N_STOP - 1) * 4);

        // Asynchronous reset in the middle of a frame.
        drive_accept(8'h00, 0, 0, 8); DATA_VALID = 1'b0;
        repeat (30) @(negedge CLK_TX);
        check_eq("pre_rst_tx", TX_OUT, 0);
        #2 RST_TX = 1'b0;
        #1;
        check_eq("async_rst_tx", TX_OUT, 1);
        check_eq("async_rst_busy", busy, 0);
        @(negedge CLK_TX);
        RST_TX = 1'b1;
        @(negedge CLK_TX);
        drive_accept(8'hC3, 1, 0, 7); DATA_VALID = 1'b0;
        capture(8'hC3, 1, 0, 7, -1, len);

        for (int i = 0; i < 12; i++) begin
            rd  = DW'($urandom);
            rpe = 1'($urandom);
            rpt = 1'($urandom);
            rps = $urandom_range(0, 20);
            repeat ($urandom_range(0, 3)) @(negedge CLK_TX);
            drive_accept(rd, rpe, rpt, rps); DATA_VALID = 1'b0;
            capture(rd, rpe, rpt, rps, -1, len);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_frame

`default_nettype wire
